// File: rtl/digit_step_ctrl_if.sv
// Bundle of step-controller signals between the control source and digit_step_ctrl.
//   btn_up, btn_down : raw asynchronous buttons (1 = pressed)
//   tick             : synchronous one-cycle count enable
//   run              : 1 = count on tick, 0 = set mode (buttons step)
//   add, sub         : one-cycle units step pulses
//   addb, subb       : one-cycle carry/borrow pulses into tens
//   wrap             : one-cycle 59<->00 wrap pulse
//   units, tens      : registered digit values
interface digit_step_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       tick;
    logic       run;
    logic       add;
    logic       sub;
    logic       addb;
    logic       subb;
    logic       wrap;
    logic [3:0] units;
    logic [3:0] tens;

    // Source side: drives the step controls, observes the digits and pulses.
    modport master (
        output btn_up, btn_down, tick, run,
        input  add, sub, addb, subb, wrap, units, tens
    );

    // Controller side.
    modport slave (
        input  btn_up, btn_down, tick, run,
        output add, sub, addb, subb, wrap, units, tens
    );
endinterface

// File: rtl/digit_step_ctrl.sv
// Two-digit (tens 0-5, units 0-9) step controller. Owns the digit registers and emits
// registered one-cycle add/sub/addb/subb/wrap pulses for the downstream digit adders.
// Buttons are synchronised (2 flops), debounced and rising-edge detected.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   io_bus : digit_step_ctrl_if.slave (buttons, tick, run in; digits, pulses out)
module digit_step_ctrl #(
    parameter int unsigned DB_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    digit_step_ctrl_if.slave io_bus
);

    localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    // Index 0 = up button, 1 = down button.
    logic [1:0]      w_raw;
    logic [1:0]      r_meta;
    logic [1:0]      r_sync;
    logic [1:0]      r_stable;
    logic [1:0]      r_press;
    logic [CntW-1:0] r_cnt [2];

    logic       r_add, r_sub, r_addb, r_subb, r_wrap;
    logic [3:0] r_units, r_tens;

    logic       w_up_req, w_dn_req, w_do_up, w_do_dn;
    logic       w_add, w_sub, w_addb, w_subb, w_wrap;
    logic [3:0] w_units, w_tens;

    assign w_raw = {io_bus.btn_down, io_bus.btn_up};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    // Debounce: the stable level flips after DB_CYCLES consecutive disagreeing cycles.
    // The press pulse is registered on the same edge as the 0->1 flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            r_press  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CntLast) begin
                    r_cnt[i]    <= '0;
                    r_stable[i] <= r_sync[i];
                    r_press[i]  <= r_sync[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Presses arriving in run mode are simply dropped here, never queued.
    assign w_up_req = (io_bus.run & io_bus.tick) | (~io_bus.run & r_press[0]);
    assign w_dn_req = ~io_bus.run & r_press[1];
    assign w_do_up  = w_up_req & ~w_dn_req;
    assign w_do_dn  = w_dn_req & ~w_up_req;

    always_comb begin
        w_units = r_units;
        w_tens  = r_tens;
        w_add   = 1'b0;
        w_sub   = 1'b0;
        w_addb  = 1'b0;
        w_subb  = 1'b0;
        w_wrap  = 1'b0;
        if (w_do_up) begin
            w_add = 1'b1;
            if (r_units < 4'd9) begin
                w_units = r_units + 4'd1;
            end else begin
                w_units = 4'd0;
                w_addb  = 1'b1;
                if (r_tens < 4'd5) begin
                    w_tens = r_tens + 4'd1;
                end else begin
                    w_tens = 4'd0;
                    w_wrap = 1'b1;
                end
            end
        end else if (w_do_dn) begin
            w_sub = 1'b1;
            if (r_units != 4'd0) begin
                w_units = r_units - 4'd1;
            end else begin
                w_units = 4'd9;
                w_subb  = 1'b1;
                if (r_tens != 4'd0) begin
                    w_tens = r_tens - 4'd1;
                end else begin
                    w_tens = 4'd5;
                    w_wrap = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_add   <= 1'b0;
            r_sub   <= 1'b0;
            r_addb  <= 1'b0;
            r_subb  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_units <= w_units;
            r_tens  <= w_tens;
            r_add   <= w_add;
            r_sub   <= w_sub;
            r_addb  <= w_addb;
            r_subb  <= w_subb;
            r_wrap  <= w_wrap;
        end
    end

    assign io_bus.units = r_units;
    assign io_bus.tens  = r_tens;
    assign io_bus.add   = r_add;
    assign io_bus.sub   = r_sub;
    assign io_bus.addb  = r_addb;
    assign io_bus.subb  = r_subb;
    assign io_bus.wrap  = r_wrap;

endmodule

// File: tb/tb_digit_step_ctrl.sv
// Directed self-checking bench for digit_step_ctrl with DB_CYCLES = 4.
// Outputs are sampled 1 time unit after each rising edge; inputs change right after sampling.
module tb_digit_step_ctrl;

    logic clk = 1'b0;
    logic rst;

    digit_step_ctrl_if bus_if ();

    digit_step_ctrl #(
        .DB_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Pulse tallies and the digit/pulse state seen on the most recent pulse cycle.
    int n_add, n_sub, n_addb, n_subb, n_wrap;
    int snap_units, snap_tens, snap_addb, snap_subb, snap_wrap;

    task automatic check(input string tag, input int obs, input int want);
        n_vec++;
        if (obs != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic zero_counts();
        n_add  = 0;
        n_sub  = 0;
        n_addb = 0;
        n_subb = 0;
        n_wrap = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (bus_if.add)  n_add++;
        if (bus_if.sub)  n_sub++;
        if (bus_if.addb) n_addb++;
        if (bus_if.subb) n_subb++;
        if (bus_if.wrap) n_wrap++;
        if (bus_if.add | bus_if.sub | bus_if.addb | bus_if.subb | bus_if.wrap) begin
            snap_units = int'(bus_if.units);
            snap_tens  = int'(bus_if.tens);
            snap_addb  = int'(bus_if.addb);
            snap_subb  = int'(bus_if.subb);
            snap_wrap  = int'(bus_if.wrap);
        end
        check("add_sub_excl", int'(bus_if.add & bus_if.sub), 0);
        check("units_range", int'(bus_if.units <= 4'd9), 1);
        check("tens_range", int'(bus_if.tens <= 4'd5), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Hold the chosen buttons for 'hold' sampling edges, release, then let release settle.
    task automatic press(input logic up, input logic dn, input int hold);
        bus_if.btn_up   = up;
        bus_if.btn_down = dn;
        idle(hold);
        bus_if.btn_up   = 1'b0;
        bus_if.btn_down = 1'b0;
        idle(10);
    endtask

    task automatic check_digits(input string tag, input int want_tens, input int want_units);
        check({tag, "_tens"}, int'(bus_if.tens), want_tens);
        check({tag, "_units"}, int'(bus_if.units), want_units);
    endtask

    function automatic int any_pulse();
        return int'(bus_if.add | bus_if.sub | bus_if.addb | bus_if.subb | bus_if.wrap);
    endfunction

    initial begin
        int want;
        rst             = 1'b1;
        bus_if.btn_up   = 1'b1;
        bus_if.btn_down = 1'b0;
        bus_if.tick     = 1'b0;
        bus_if.run      = 1'b1;
        zero_counts();

        // Reset holds everything clear even with tick toggling and btn_up pressed.
        for (int i = 0; i < 6; i++) begin
            if (i == 3) bus_if.run = 1'b0;
            bus_if.tick = ~bus_if.tick;
            cycle();
            check_digits("rst_hold", 0, 0);
            check("rst_pulses", any_pulse(), 0);
        end

        // Release: first sampling edge is edge 1, step appears after edge 3+DB = 7.
        rst         = 1'b0;
        bus_if.tick = 1'b0;
        bus_if.run  = 1'b0;
        zero_counts();
        for (int i = 1; i <= 6; i++) begin
            cycle();
            check("rst_lat_early_add", int'(bus_if.add), 0);
        end
        cycle();
        check("rst_lat_add", int'(bus_if.add), 1);
        check_digits("rst_lat", 0, 1);
        idle(10);
        check("rst_hold_one_step", n_add, 1);
        bus_if.btn_up = 1'b0;
        idle(10);

        // Run mode: 60 ticks from 00.
        do_reset();
        bus_if.run = 1'b1;
        zero_counts();
        for (int i = 0; i < 60; i++) begin
            bus_if.tick = 1'b1;
            cycle();
            bus_if.tick = 1'b0;
            want = (i + 1) % 60;
            check_digits("run_step", want / 10, want % 10);
            check("run_add", int'(bus_if.add), 1);
            check("run_addb", int'(bus_if.addb), (want % 10 == 0) ? 1 : 0);
            check("run_wrap", int'(bus_if.wrap), (want == 0) ? 1 : 0);
            cycle();
            check("run_gap_pulses", any_pulse(), 0);
        end
        check("run_n_add", n_add, 60);
        check("run_n_addb", n_addb, 6);
        check("run_n_wrap", n_wrap, 1);
        check("run_n_sub", n_sub, 0);
        bus_if.run = 1'b0;

        // Down wrap from 00.
        zero_counts();
        press(1'b0, 1'b1, 12);
        check("dn1_n_sub", n_sub, 1);
        check("dn1_n_subb", n_subb, 1);
        check("dn1_n_wrap", n_wrap, 1);
        check("dn1_snap_tens", snap_tens, 5);
        check("dn1_snap_units", snap_units, 9);
        check_digits("dn1", 5, 9);
        zero_counts();
        press(1'b0, 1'b1, 12);
        check("dn2_n_sub", n_sub, 1);
        check("dn2_n_subb", n_subb, 0);
        check("dn2_n_wrap", n_wrap, 0);
        check("dn2_snap_units", snap_units, 8);
        check_digits("dn2", 5, 8);

        // Glitch shorter than DB_CYCLES, then a real 6-cycle press.
        zero_counts();
        press(1'b1, 1'b0, 3);
        check("glitch_n_add", n_add, 0);
        check("glitch_n_sub", n_sub, 0);
        check_digits("glitch", 5, 8);
        press(1'b1, 1'b0, 6);
        check("press6_n_add", n_add, 1);
        check("press6_n_addb", n_addb, 0);
        check_digits("press6", 5, 9);

        // Simultaneous presses at 30 cancel.
        do_reset();
        bus_if.run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus_if.tick = 1'b1;
            cycle();
            bus_if.tick = 1'b0;
        end
        bus_if.run = 1'b0;
        check_digits("at30", 3, 0);
        zero_counts();
        press(1'b1, 1'b1, 12);
        check("both_n_pulses", n_add + n_sub + n_addb + n_subb + n_wrap, 0);
        check_digits("both", 3, 0);

        // Mode gating.
        bus_if.run = 1'b1;
        zero_counts();
        press(1'b1, 1'b0, 12);
        check("gate_run_btn", n_add + n_sub, 0);
        bus_if.run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_if.tick = 1'b1;
            cycle();
        end
        bus_if.tick = 1'b0;
        check("gate_set_tick", n_add + n_sub, 0);
        check_digits("gate", 3, 0);

        // Press lands while run=1 and must not fire after run drops back.
        bus_if.btn_up = 1'b1;
        idle(3);
        bus_if.run = 1'b1;
        idle(6);
        bus_if.run = 1'b0;
        idle(6);
        bus_if.btn_up = 1'b0;
        idle(10);
        check("gate_no_queue", n_add + n_sub, 0);
        check_digits("gate_q", 3, 0);

        // Set mode still works afterwards.
        press(1'b1, 1'b0, 12);
        check("gate_after_add", n_add, 1);
        check_digits("gate_after", 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/digit_step_ctrl.md
# digit_step_ctrl

Two-digit (tens 0–5, units 0–9) step controller that owns the digit registers and produces the one-cycle add/sub and addb/subb step pulses consumed by the digit adder stage. It sits directly upstream of the digit adders. Step sources are raw up/down buttons in set mode and a periodic tick in run mode. Button inputs are synchronised, debounced and edge-detected.

## Interface
- DB_CYCLES, 16: consecutive cycles a synchronised button level must differ from its debounced level before the debounced level flips. Legal range ≥2. Debounce counter width is ceil(log2(DB_CYCLES+1)).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- btn_up  in  1  raw, asynchronous up button (1 = pressed)
- btn_down  in  1  raw, asynchronous down button
- tick  in  1  synchronous one-cycle count enable
- run  in  1  1 = count up on tick and ignore buttons; 0 = set mode, buttons step, tick ignored
- add  out  1  one-cycle pulse: units stepped up
- sub  out  1  one-cycle pulse: units stepped down
- addb  out  1  one-cycle pulse: carry into tens (units 9→0 on up)
- subb  out  1  one-cycle pulse: borrow from tens (units 0→9 on down)
- wrap  out  1  one-cycle pulse: 59→00 (up) or 00→59 (down)
- units  out  4  registered units digit, 0–9
- tens  out  4  registered tens digit, 0–5

## Operation
- Reset (async, rst=1): units=0, tens=0, add/sub/addb/subb/wrap=0. Synchroniser flops=0, debounced levels=0, debounce counters=0, press registers=0.
- Synchroniser: each button passes through 2 flops. s_up and s_dn are the second-flop outputs.
- Debouncer, per button:
  - If s == stable, the counter clears.
  - Otherwise the counter increments. On the edge where it would reach DB_CYCLES, stable flips and the counter clears.
  - Debouncers run in both modes.
- Press register: set for exactly one cycle on the edge where stable goes 0→1. Release (1→0) generates nothing.
- Step request, evaluated each cycle:
  - up_req = (run & tick) | (~run & up_press)
  - dn_req = ~run & dn_press
  - up_req & dn_req together: no step and no pulses (cancel).
- Up step:
  - units<9: units+1; add=1.
  - units=9, tens<5: units=0, tens+1; add=1, addb=1.
  - units=9, tens=5: units=0, tens=0; add=1, addb=1, wrap=1.
- Down step:
  - units>0: units−1; sub=1.
  - units=0, tens>0: units=9, tens−1; sub=1, subb=1.
  - units=0, tens=0: units=9, tens=5; sub=1, subb=1, wrap=1.
- Pulse outputs are registered and assert in the same cycle the new digit values appear. They are 0 on every cycle without a step. add and sub are never both 1.
- Digits never leave the legal ranges. No other state exists.
- A mode change (run toggling) takes effect on the next evaluation. A press pulse that lands while run=1 is discarded, not queued.

## Timing
- Tick path: tick=1 sampled at edge n (run=1). After edge n, digits are updated and the pulses are high for one cycle. Latency is 1.
- Button path: btn_up rises and is stable before edge 1.
  - s_up=1 after edge 2.
  - Counter counts edges 3..2+DB_CYCLES. stable=1 and up_press=1 after edge 2+DB_CYCLES.
  - Digits update and add=1 after edge 3+DB_CYCLES.
- A glitch that keeps s differing from stable for fewer than DB_CYCLES consecutive cycles produces no step.
- Holding a button produces exactly one step. There is no auto-repeat.
- rst asserted mid-debounce or mid-pulse clears everything immediately. The first step after rst deasserts needs the full button latency again.

## Test plan
- Reset: assert rst with btn_up=1 and tick toggling. Required: units=0, tens=0, all pulses 0 while rst=1. After release with DB_CYCLES=4 and btn_up held, exactly one add pulse occurs, 7 cycles after the first sampling edge.
- Run count: run=1, 60 tick pulses from 00.
  - Digits pass 09→10 with add=addb=1.
  - 59→00 with add=addb=wrap=1.
  - Exactly 60 add pulses and 6 addb pulses total.
- Down wrap: run=0, DB_CYCLES=4, press btn_down from 00. Required: 59 with sub=subb=wrap=1. A second press gives 58 with sub=1 and subb=0.
- Debounce glitch: btn_up high for 3 cycles (DB_CYCLES=4). Required: no pulse, digits unchanged. A 6-cycle press yields exactly one add.
- Simultaneous presses: debounced up_press and dn_press fire in the same cycle at 30. Required: digits stay 30, all pulses 0.
- Mode gating: run=1 with a btn_up press gives no button step. run=0 with tick pulses gives no step. Switching run mid-debounce still produces no queued step.
